// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 radix-2 steps per operation.
// Optional divide datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled on a rising edge only while busy=0; a taken
  // request is acknowledged by a one-cycle done pulse once HI/LO are updated.
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
  logic [5:0]         cnt;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // op[0]=0 selects the signed variants (mult, div)
  assign a_neg = ~op_q[0] & a_q[WIDTH-1];
  assign b_neg = ~op_q[0] & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Restoring step: remainder never exceeds the divisor, so WIDTH bits suffice
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand});
  assign div_diff  = div_shift[WIDTH-1:0] - mcand;
  assign quo_fix   = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
  assign rem_fix   = a_neg ? -acc_hi : acc_hi;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_nxt = S_PREP;
`else
          // Without a divider, divides complete immediately with no effect
          state_nxt = op[1] ? S_FIX : S_PREP;
`endif
        end
      end
      S_PREP:  state_nxt = S_RUN;
      S_RUN:   if (cnt == 6'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_PREP: begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          mcand  <= b_mag;
          cnt    <= '0;
        end
        S_RUN: begin
          cnt <= cnt + 6'd1;
`ifdef MULDIV_DIV_EN
          if (op_q[1]) begin
            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
`else
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
`endif
        end
        S_FIX: begin
`ifdef MULDIV_DIV_EN
          if (op_q[1]) begin
            if (b_q == '0) begin
              lo   <= '1;
              hi   <= a_q;
              div0 <= 1'b1;
            end else begin
              lo   <= quo_fix;
              hi   <= rem_fix;
              div0 <= 1'b0;
            end
          end else begin
            {hi, lo} <= prod_fix;
            div0     <= 1'b0;
          end
`else
          if (!op_q[1]) {hi, lo} <= prod_fix;
          div0 <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
